// File: rtl/lc3_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// lc3_ctrl_fsm
// Control-unit state machine for a small LC-3 datapath. It sequences
// instruction fetch, decode and execute for ADD/AND/NOT/BR/JMP/JSR/LDR/STR
// and a PAUSE instruction that waits for the user's Continue button.
// Every datapath control line is decoded from the current state only, apart
// from SR2MUX, which follows IR_5.
//
// Parameters
//   MEM_WAIT  SRAM access cycles per read or write (1..15)
//   CW        width of the memory wait counter
//
// Ports
//   Clk, Reset                  clock, synchronous active-high reset
//   Run, Continue               user start / resume buttons
//   Opcode, IR_5, IR_11, BEN    instruction fields and branch-enable flag
//   LD_*                        register load enables
//   Gate*                       bus drivers (at most one per cycle)
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK   mux selects
//   Mem_OE, Mem_WE              active-high SRAM strobes
//
// Build option
//   LC3_PAUSE_IR_EN  when defined, the FSM stops after loading IR
//                    (S35 -> PIR1 -> PIR2 -> S32) so the IR can be inspected.
// ---------------------------------------------------------------------------
module lc3_ctrl_fsm #(
  parameter int MEM_WAIT = 2,
  parameter int CW       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S25, S27,
    S07, S23, S16, S13, P1, P2
`ifdef LC3_PAUSE_IR_EN
    , PIR1, PIR2
`endif
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          wait_done;
  logic          load_wait;

  assign wait_done = (wait_cnt == '0);

  // The wait counter is loaded with MEM_WAIT-1 on entry to a memory state and
  // counts down to zero; zero marks the final access cycle. Reset clears it so
  // an aborted access leaves no stale count behind.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (load_wait)
        wait_cnt <= CW'(MEM_WAIT - 1);
      else if (!wait_done)
        wait_cnt <= wait_cnt - CW'(1);
    end
  end

  always_comb begin
    next_state = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    unique case (state)
      HALTED: if (Run) next_state = S18;

      S18: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        LD_PC      = 1'b1;
        PCMUX      = 2'b00;
        next_state = S33;
      end

      S33: begin
        Mem_OE = 1'b1;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          next_state = S35;
        end
      end

      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
`ifdef LC3_PAUSE_IR_EN
        next_state = PIR1;
`else
        next_state = S32;
`endif
      end

`ifdef LC3_PAUSE_IR_EN
      PIR1: if (Continue)  next_state = PIR2;
      PIR2: if (!Continue) next_state = S32;
`endif

      S32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: next_state = S01;
          4'b0101: next_state = S05;
          4'b1001: next_state = S09;
          4'b0000: next_state = S00;
          4'b1100: next_state = S12;
          4'b0100: next_state = S04;
          4'b0110: next_state = S06;
          4'b0111: next_state = S07;
          4'b1101: next_state = S13;
          default: next_state = S18;
        endcase
      end

      S01, S05: begin
        SR1MUX     = 1'b1;
        SR2MUX     = IR_5;
        ALUK       = (state == S05) ? 2'b01 : 2'b00;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = S18;
      end

      S09: begin
        SR1MUX     = 1'b1;
        ALUK       = 2'b10;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = S18;
      end

      S00: next_state = BEN ? S22 : S18;

      S22: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b10;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        next_state = S18;
      end

      // JMP and the register form of JSR both pass the base register
      // straight through the ALU onto the bus and load it into PC.
      S12, S20: begin
        SR1MUX     = 1'b1;
        ALUK       = 2'b11;
        GateALU    = 1'b1;
        PCMUX      = 2'b01;
        LD_PC      = 1'b1;
        next_state = S18;
      end

      S04: begin
        GatePC     = 1'b1;
        DRMUX      = 1'b1;
        LD_REG     = 1'b1;
        next_state = IR_11 ? S21 : S20;
      end

      S21: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b11;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        next_state = S18;
      end

      // LDR and STR form the address BaseR + off6 the same way.
      S06, S07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        next_state = (state == S06) ? S25 : S23;
      end

      S25: begin
        Mem_OE = 1'b1;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          next_state = S27;
        end
      end

      S27: begin
        GateMDR    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = S18;
      end

      // SR1MUX=0 selects IR[11:9], the STR source register.
      S23: begin
        SR1MUX     = 1'b0;
        ALUK       = 2'b11;
        GateALU    = 1'b1;
        LD_MDR     = 1'b1;
        next_state = S16;
      end

      S16: begin
        Mem_WE = 1'b1;
        if (wait_done) next_state = S18;
      end

      S13: begin
        LD_LED     = 1'b1;
        next_state = P1;
      end

      P1: if (Continue)  next_state = P2;
      P2: if (!Continue) next_state = S18;

      default: next_state = HALTED;
    endcase

    load_wait = (next_state != state) &&
                ((next_state == S33) || (next_state == S25) || (next_state == S16));
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_lc3_ctrl_fsm
// Randomized self-checking bench for lc3_ctrl_fsm (default build, pause-after-
// IR option disabled). A reference model expands each instruction into its
// expected per-cycle control-word trace together with the input values to
// drive on each cycle. The driver plays the trace and pushes each expected
// word into a scoreboard queue; an independent monitor pops one word per
// cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_lc3_ctrl_fsm;

  localparam int MW = 3;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctl_t;

  typedef struct packed {
    logic       reset, run, cont;
    logic [3:0] opc;
    logic       ir5, ir11, ben;
    ctl_t       exp;
  } cyc_t;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic       Mem_OE, Mem_WE;

  cyc_t trace[$];
  ctl_t exp_q[$];
  logic chk_on = 1'b0;
  int   cyc_no = 0;
  int   total = 0;
  int   bad = 0;

  logic [3:0] cur_opc;
  logic       cur_ir5, cur_ir11, cur_ben;

  lc3_ctrl_fsm #(.MEM_WAIT(MW), .CW(4)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  // ---------------- reference model: instruction -> cycle trace ----------
  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push_cyc(input ctl_t e, input logic cont);
    cyc_t c;
    c.reset = 1'b0;
    c.run   = rbit();
    c.cont  = cont;
    c.opc   = cur_opc;
    c.ir5   = cur_ir5;
    c.ir11  = cur_ir11;
    c.ben   = cur_ben;
    c.exp   = e;
    trace.push_back(c);
  endtask

  task automatic mem_access(input bit write);
    ctl_t v;
    for (int i = 0; i < MW; i++) begin
      v = '0;
      if (write) v.mem_we = 1'b1;
      else begin
        v.mem_oe = 1'b1;
        v.ld_mdr = (i == MW - 1);
      end
      push_cyc(v, rbit());
    end
  endtask

  task automatic build_instr(input logic [3:0] opc, input logic ir5,
                             input logic ir11, input logic ben, input int abort_at);
    ctl_t v;
    cyc_t c;
    int   start;
    int   cut;
    int   w1;
    int   w2;
    start    = trace.size();
    cur_opc  = opc;
    cur_ir5  = ir5;
    cur_ir11 = ir11;
    cur_ben  = ben;

    v = '0; v.gate_pc = 1; v.ld_mar = 1; v.ld_pc = 1; v.pcmux = 2'b00;
    push_cyc(v, rbit());
    mem_access(1'b0);
    v = '0; v.gate_mdr = 1; v.ld_ir = 1;
    push_cyc(v, rbit());
    v = '0; v.ld_ben = 1;
    push_cyc(v, rbit());

    case (opc)
      4'b0001, 4'b0101: begin
        v = '0; v.sr1mux = 1; v.sr2mux = ir5; v.aluk = (opc == 4'b0101) ? 2'b01 : 2'b00;
        v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1;
        push_cyc(v, rbit());
      end
      4'b1001: begin
        v = '0; v.sr1mux = 1; v.aluk = 2'b10; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1;
        push_cyc(v, rbit());
      end
      4'b0000: begin
        push_cyc('0, rbit());
        if (ben) begin
          v = '0; v.addr2mux = 2'b10; v.pcmux = 2'b10; v.ld_pc = 1;
          push_cyc(v, rbit());
        end
      end
      4'b1100: begin
        v = '0; v.sr1mux = 1; v.aluk = 2'b11; v.gate_alu = 1; v.pcmux = 2'b01; v.ld_pc = 1;
        push_cyc(v, rbit());
      end
      4'b0100: begin
        v = '0; v.gate_pc = 1; v.drmux = 1; v.ld_reg = 1;
        push_cyc(v, rbit());
        v = '0;
        if (ir11) begin
          v.addr2mux = 2'b11; v.pcmux = 2'b10; v.ld_pc = 1;
        end else begin
          v.sr1mux = 1; v.aluk = 2'b11; v.gate_alu = 1; v.pcmux = 2'b01; v.ld_pc = 1;
        end
        push_cyc(v, rbit());
      end
      4'b0110, 4'b0111: begin
        v = '0; v.sr1mux = 1; v.addr1mux = 1; v.addr2mux = 2'b01; v.gate_marmux = 1; v.ld_mar = 1;
        push_cyc(v, rbit());
        if (opc == 4'b0110) begin
          mem_access(1'b0);
          v = '0; v.gate_mdr = 1; v.ld_reg = 1; v.ld_cc = 1;
          push_cyc(v, rbit());
        end else begin
          v = '0; v.aluk = 2'b11; v.gate_alu = 1; v.ld_mdr = 1;
          push_cyc(v, rbit());
          mem_access(1'b1);
        end
      end
      4'b1101: begin
        w1 = $urandom_range(0, 3);
        w2 = $urandom_range(0, 3);
        v = '0; v.ld_led = 1;
        push_cyc(v, rbit());
        for (int i = 0; i < w1; i++) push_cyc('0, 1'b0);
        push_cyc('0, 1'b1);
        for (int i = 0; i < w2; i++) push_cyc('0, 1'b1);
        push_cyc('0, 1'b0);
      end
      default: ;
    endcase

    // A reset in cycle 'abort_at' of this instruction cuts the trace there.
    if (abort_at >= 0) begin
      cut = start + abort_at;
      if (cut > trace.size() - 1) cut = trace.size() - 1;
      while (trace.size() > cut + 1) void'(trace.pop_back());
      c = trace.pop_back();
      c.reset = 1'b1;
      trace.push_back(c);
    end
  endtask

  // HALTED: idle cycles (some with Reset, possibly together with Run, which
  // must lose), then one Run pulse that starts the fetch.
  task automatic add_halted(input int nidle);
    cyc_t c;
    for (int i = 0; i <= nidle; i++) begin
      c       = '0;
      c.opc   = 4'($urandom_range(0, 15));
      c.cont  = rbit();
      if (i == nidle) begin
        c.run = 1'b1;
      end else begin
        c.reset = rbit();
        c.run   = c.reset ? rbit() : 1'b0;
      end
      trace.push_back(c);
    end
  endtask

  // ---------------- driver --------------------------------------------
  task automatic apply_stimulus(input cyc_t c);
    Reset    = c.reset;
    Run      = c.run;
    Continue = c.cont;
    Opcode   = c.opc;
    IR_5     = c.ir5;
    IR_11    = c.ir11;
    BEN      = c.ben;
    exp_q.push_back(c.exp);
  endtask

  // ---------------- monitor -------------------------------------------
  task automatic check_output(input ctl_t got, input ctl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL cycle %0d ctrl_word got=%06h expected=%06h", cyc_no, got, exp);
    end
    total++;
    if ((got.mem_oe & got.mem_we) !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cycle %0d oe_we_exclusive got OE=%b WE=%b expected not both", cyc_no, got.mem_oe, got.mem_we);
    end
    total++;
    if ($countones({got.gate_pc, got.gate_mdr, got.gate_alu, got.gate_marmux}) > 1) begin
      bad++;
      $display("[TB] FAIL cycle %0d single_gate got=%b expected at most one", cyc_no,
               {got.gate_pc, got.gate_mdr, got.gate_alu, got.gate_marmux});
    end
  endtask

  always @(negedge Clk) begin
    ctl_t got;
    if (chk_on) begin
      cyc_no++;
      got = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
             GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
             DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL cycle %0d scoreboard_underflow got=%06h expected=entry", cyc_no, got);
      end else begin
        check_output(got, exp_q.pop_front());
      end
    end
  end

  // ---------------- test program ---------------------------------------
  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'b0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

    add_halted(2);
    build_instr(4'b0001, 1'b1, 1'b0, 1'b0, -1);   // ADD, immediate form
    build_instr(4'b0000, 1'b0, 1'b0, 1'b0, -1);   // BR not taken
    build_instr(4'b0000, 1'b0, 1'b0, 1'b1, -1);   // BR taken
    build_instr(4'b0111, 1'b0, 1'b0, 1'b0, -1);   // STR
    build_instr(4'b1101, 1'b0, 1'b0, 1'b0, -1);   // PAUSE
    build_instr(4'b0110, 1'b0, 1'b0, 1'b0, -1);   // LDR
    build_instr(4'b0100, 1'b0, 1'b1, 1'b0, -1);   // JSR
    build_instr(4'b0100, 1'b0, 1'b0, 1'b0, -1);   // JSRR
    build_instr(4'b1100, 1'b0, 1'b0, 1'b0, -1);   // JMP
    build_instr(4'b1001, 1'b0, 1'b0, 1'b0, -1);   // NOT
    build_instr(4'b0101, 1'b0, 1'b0, 1'b0, -1);   // AND, register form
    build_instr(4'b1111, 1'b0, 1'b0, 1'b0, -1);   // undecoded opcode
    build_instr(4'b0001, 1'b0, 1'b0, 1'b0, 2);    // reset in 2nd S33 cycle
    add_halted(1);
    build_instr(4'b0111, 1'b0, 1'b0, 1'b0, 6);    // reset during the store
    add_halted(0);

    for (int n = 0; n < 80; n++) begin
      int ab;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : -1;
      build_instr(4'($urandom_range(0, 15)), rbit(), rbit(), rbit(), ab);
      if (ab >= 0) add_halted($urandom_range(0, 2));
    end

    @(posedge Clk); #1;
    chk_on = 1'b1;
    for (int j = 0; j < trace.size(); j++) begin
      apply_stimulus(trace[j]);
      @(posedge Clk); #1;
    end
    chk_on = 1'b0;
    @(posedge Clk); #1;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got=%0d leftover expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
